// File: rtl/turn_fire_controller.sv
// ---------------------------------------------------------------------------
// turn_fire_controller
//
// Frame-rate game sequencer for a two-turret duel. Both turrets share one
// projectile. This block tracks whose turn it is, both aim indices, the
// projectile position and velocity, deflector and wall bounces, misses and
// hits, and the scores. The draw logic reads the aim indices and the bullet
// position. The pixel-detect path returns the deflector and target collision
// flags.
//
// Ports
//   frame_clk      in   1   frame-rate clock, all state updates on rising edge
//   Reset          in   1   synchronous, active-high
//   keycode        in   8   current USB keycode, held while the key is down
//   hit_deflector  in   1   bullet overlaps a deflector pixel this frame
//   hit_target     in   1   bullet overlaps the opponent sprite this frame
//   turret_l       out  4   left aim index, 0..8
//   turret_r       out  4   right aim index, 0..8
//   b_pos_x        out  10  bullet top-left x
//   b_pos_y        out  10  bullet top-left y
//   b_exist        out  1   bullet is drawn
//   b_dir          out  1   0 = moving right, 1 = moving left
//   active_player  out  1   0 = left, 1 = right
//   score_l        out  4   left score
//   score_r        out  4   right score
//   game_over      out  1   a player has reached WIN_SCORE
// ---------------------------------------------------------------------------
module turn_fire_controller #(
   parameter int L_MUZZLE_X = 90,
   parameter int L_MUZZLE_Y = 52,
   parameter int R_MUZZLE_X = 510,
   parameter int R_MUZZLE_Y = 420,
   parameter int BULLET_W   = 40,
   parameter int BULLET_H   = 10,
   parameter int SCREEN_W   = 640,
   parameter int SCREEN_H   = 480,
   parameter int COOLDOWN   = 30,
   parameter int ANGLE_INIT = 4,
   parameter int WIN_SCORE  = 5
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic [7:0] keycode,
   input  logic       hit_deflector,
   input  logic       hit_target,
   output logic [3:0] turret_l,
   output logic [3:0] turret_r,
   output logic [9:0] b_pos_x,
   output logic [9:0] b_pos_y,
   output logic       b_exist,
   output logic       b_dir,
   output logic       active_player,
   output logic [3:0] score_l,
   output logic [3:0] score_r,
   output logic       game_over
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_FLIGHT,
      S_COOL,
      S_OVER
   } state_t;

   localparam logic [7:0] K_L_DEC  = 8'h1A;
   localparam logic [7:0] K_L_INC  = 8'h16;
   localparam logic [7:0] K_L_FIRE = 8'h2C;
   localparam logic [7:0] K_R_DEC  = 8'h52;
   localparam logic [7:0] K_R_INC  = 8'h51;
   localparam logic [7:0] K_R_FIRE = 8'h28;

   // Geometry as 12-bit signed so that edge tests cannot wrap.
   localparam logic signed [11:0] BW_S = 12'(BULLET_W);
   localparam logic signed [11:0] BH_S = 12'(BULLET_H);
   localparam logic signed [11:0] SW_S = 12'(SCREEN_W);
   localparam logic signed [11:0] SH_S = 12'(SCREEN_H);

   localparam logic [9:0] CD_LAST     = 10'(COOLDOWN - 1);
   localparam logic [9:0] FLIGHT_LAST = 10'd1022;

   state_t            state_q, state_d;
   logic [7:0]        key_q, key_d;
   logic [3:0]        tl_q, tl_d, tr_q, tr_d;
   logic [9:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic signed [2:0] dx_q, dx_d, dy_q, dy_d;
   logic              exist_q, exist_d, dir_q, dir_d, player_q, player_d;
   logic [3:0]        score_l_q, score_l_d, score_r_q, score_r_d;
   logic              over_q, over_d, lock_q, lock_d;
   logic [9:0]        cnt_q, cnt_d;

   function automatic logic [3:0] aim_dec(input logic [3:0] a);
      return (a == 4'd0) ? 4'd0 : a - 4'd1;
   endfunction

   function automatic logic [3:0] aim_inc(input logic [3:0] a);
      return (a >= 4'd8) ? 4'd8 : a + 4'd1;
   endfunction

   function automatic logic [3:0] score_inc(input logic [3:0] s);
      return (s == 4'hF) ? s : s + 4'd1;
   endfunction

   function automatic logic signed [2:0] vel_dx(input logic [3:0] idx);
      case (idx)
         4'd0, 4'd8: return 3'sd0;
         4'd1, 4'd7: return 3'sd1;
         default:    return 3'sd2;
      endcase
   endfunction

   function automatic logic signed [2:0] vel_dy(input logic [3:0] idx);
      case (idx)
         4'd0, 4'd1, 4'd2: return -3'sd2;
         4'd3:             return -3'sd1;
         4'd4:             return 3'sd0;
         4'd5:             return 3'sd1;
         default:          return 3'sd2;
      endcase
   endfunction

   logic                key_ev;
   logic [3:0]          aim_idx;
   logic signed [2:0]   dx_base, dx_launch;
   logic signed [11:0]  x_s, y_s, dx_s, dy_s;
   logic                dx_pos, miss_r, miss_l, wall_v;

   // A key acts only on the frame it first differs from the previous frame.
   assign key_ev = (keycode != 8'h00) && (keycode != key_q);

   assign aim_idx   = player_q ? tr_q : tl_q;
   assign dx_base   = vel_dx(aim_idx);
   assign dx_launch = player_q ? (3'sd0 - dx_base) : dx_base;

   assign x_s    = $signed({2'b00, pos_x_q});
   assign y_s    = $signed({2'b00, pos_y_q});
   assign dx_s   = $signed({{9{dx_q[2]}}, dx_q});
   assign dy_s   = $signed({{9{dy_q[2]}}, dy_q});
   assign dx_pos = !dx_q[2] && (dx_q != 3'sd0);
   assign miss_r = dx_pos && ((x_s + BW_S + dx_s) >= SW_S);
   assign miss_l = dx_q[2] && (x_s < (12'sd0 - dx_s));
   assign wall_v = ((y_s + dy_s) < 12'sd0) || ((y_s + BH_S + dy_s) > SH_S);

   always_comb begin
      state_d   = state_q;
      key_d     = keycode;
      tl_d      = tl_q;
      tr_d      = tr_q;
      pos_x_d   = pos_x_q;
      pos_y_d   = pos_y_q;
      dx_d      = dx_q;
      dy_d      = dy_q;
      exist_d   = exist_q;
      dir_d     = dir_q;
      player_d  = player_q;
      score_l_d = score_l_q;
      score_r_d = score_r_q;
      over_d    = over_q;
      cnt_d     = cnt_q;
      // The lock stops a deflector that stays in contact for several frames
      // from reflecting the bullet again on each of those frames.
      lock_d    = hit_deflector ? lock_q : 1'b0;

      case (state_q)
         S_IDLE: begin
            if (key_ev) begin
               if (!player_q) begin
                  case (keycode)
                     K_L_DEC:  tl_d    = aim_dec(tl_q);
                     K_L_INC:  tl_d    = aim_inc(tl_q);
                     K_L_FIRE: state_d = S_LAUNCH;
                     default: ;
                  endcase
               end else begin
                  case (keycode)
                     K_R_DEC:  tr_d    = aim_dec(tr_q);
                     K_R_INC:  tr_d    = aim_inc(tr_q);
                     K_R_FIRE: state_d = S_LAUNCH;
                     default: ;
                  endcase
               end
            end
         end

         S_LAUNCH: begin
            pos_x_d = player_q ? 10'(R_MUZZLE_X) : 10'(L_MUZZLE_X);
            pos_y_d = player_q ? 10'(R_MUZZLE_Y) : 10'(L_MUZZLE_Y);
            dx_d    = dx_launch;
            dy_d    = vel_dy(aim_idx);
            exist_d = 1'b1;
            // A vertical shot has no horizontal sign. It takes its direction
            // from the shooter.
            if (dx_launch[2])
               dir_d = 1'b1;
            else if (dx_launch == 3'sd0)
               dir_d = player_q;
            else
               dir_d = 1'b0;
            cnt_d   = '0;
            state_d = S_FLIGHT;
         end

         S_FLIGHT: begin
            cnt_d = cnt_q + 10'd1;
            if (hit_target) begin
               if (!player_q) score_l_d = score_inc(score_l_q);
               else           score_r_d = score_inc(score_r_q);
               exist_d = 1'b0;
               cnt_d   = '0;
               state_d = S_COOL;
            end else if (miss_r || miss_l || (cnt_q == FLIGHT_LAST)) begin
               exist_d = 1'b0;
               cnt_d   = '0;
               state_d = S_COOL;
            end else if (hit_deflector && !lock_q) begin
               dx_d   = 3'sd0 - dx_q;
               dir_d  = ~dir_q;
               lock_d = 1'b1;
            end else if (wall_v) begin
               dy_d = 3'sd0 - dy_q;
            end else begin
               pos_x_d = pos_x_q + {{7{dx_q[2]}}, dx_q};
               pos_y_d = pos_y_q + {{7{dy_q[2]}}, dy_q};
            end
         end

         S_COOL: begin
            if (cnt_q == CD_LAST) begin
               cnt_d = '0;
               if ((score_l_q == 4'(WIN_SCORE)) || (score_r_q == 4'(WIN_SCORE))) begin
                  over_d  = 1'b1;
                  state_d = S_OVER;
               end else begin
                  player_d = ~player_q;
                  state_d  = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 10'd1;
            end
         end

         S_OVER: ;

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         key_q     <= '0;
         tl_q      <= 4'(ANGLE_INIT);
         tr_q      <= 4'(ANGLE_INIT);
         pos_x_q   <= 10'(L_MUZZLE_X);
         pos_y_q   <= 10'(L_MUZZLE_Y);
         dx_q      <= '0;
         dy_q      <= '0;
         exist_q   <= 1'b0;
         dir_q     <= 1'b0;
         player_q  <= 1'b0;
         score_l_q <= '0;
         score_r_q <= '0;
         over_q    <= 1'b0;
         lock_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         key_q     <= key_d;
         tl_q      <= tl_d;
         tr_q      <= tr_d;
         pos_x_q   <= pos_x_d;
         pos_y_q   <= pos_y_d;
         dx_q      <= dx_d;
         dy_q      <= dy_d;
         exist_q   <= exist_d;
         dir_q     <= dir_d;
         player_q  <= player_d;
         score_l_q <= score_l_d;
         score_r_q <= score_r_d;
         over_q    <= over_d;
         lock_q    <= lock_d;
         cnt_q     <= cnt_d;
      end
   end

   assign turret_l      = tl_q;
   assign turret_r      = tr_q;
   assign b_pos_x       = pos_x_q;
   assign b_pos_y       = pos_y_q;
   assign b_exist       = exist_q;
   assign b_dir         = dir_q;
   assign active_player = player_q;
   assign score_l       = score_l_q;
   assign score_r       = score_r_q;
   assign game_over     = over_q;

endmodule

// File: tb/tb_turn_fire_controller.sv
// ---------------------------------------------------------------------------
// tb_turn_fire_controller
//
// Frame-by-frame bench. A behavioural game model computes the expected
// outputs for every frame as the inputs are driven. Those expectations are
// queued and compared once the clock edge has been taken. Hand-derived spot
// checks cover the key scenarios.
// ---------------------------------------------------------------------------
module tb_turn_fire_controller;

   logic       frame_clk = 1'b0;
   logic       Reset = 1'b1;
   logic [7:0] keycode = 8'h00;
   logic       hit_deflector = 1'b0;
   logic       hit_target = 1'b0;
   logic [3:0] turret_l, turret_r, score_l, score_r;
   logic [9:0] b_pos_x, b_pos_y;
   logic       b_exist, b_dir, active_player, game_over;

   turn_fire_controller dut (
      .frame_clk     (frame_clk),
      .Reset         (Reset),
      .keycode       (keycode),
      .hit_deflector (hit_deflector),
      .hit_target    (hit_target),
      .turret_l      (turret_l),
      .turret_r      (turret_r),
      .b_pos_x       (b_pos_x),
      .b_pos_y       (b_pos_y),
      .b_exist       (b_exist),
      .b_dir         (b_dir),
      .active_player (active_player),
      .score_l       (score_l),
      .score_r       (score_r),
      .game_over     (game_over)
   );

   always #5 frame_clk = ~frame_clk;

   int total = 0;
   int bad   = 0;
   logic [63:0] exp_q[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- behavioural game model ----------------
   localparam int M_IDLE = 0, M_LAUNCH = 1, M_FLIGHT = 2, M_COOL = 3, M_OVER = 4;
   int DX[9] = '{0, 1, 2, 2, 2, 2, 2, 1, 0};
   int DY[9] = '{-2, -2, -2, -1, 0, 1, 2, 2, 2};
   int m_st, m_prev, m_tl, m_tr, m_x, m_y, m_dx, m_dy;
   int m_exist, m_dir, m_pl, m_sl, m_sr, m_over, m_lock, m_fl, m_cd;

   task automatic model_step(input int kc, input int hd, input int ht, input int rs);
      int ev, idx;
      if (rs != 0) begin
         m_st = M_IDLE; m_prev = 0; m_tl = 4; m_tr = 4; m_x = 90; m_y = 52;
         m_dx = 0; m_dy = 0; m_exist = 0; m_dir = 0; m_pl = 0; m_sl = 0;
         m_sr = 0; m_over = 0; m_lock = 0; m_fl = 0; m_cd = 0;
         return;
      end
      ev = (kc != 0 && kc != m_prev) ? 1 : 0;
      m_prev = kc;
      case (m_st)
         M_IDLE: if (ev != 0) begin
            if (m_pl == 0) begin
               if (kc == 'h1A && m_tl > 0) m_tl--;
               else if (kc == 'h16 && m_tl < 8) m_tl++;
               else if (kc == 'h2C) m_st = M_LAUNCH;
            end else begin
               if (kc == 'h52 && m_tr > 0) m_tr--;
               else if (kc == 'h51 && m_tr < 8) m_tr++;
               else if (kc == 'h28) m_st = M_LAUNCH;
            end
         end
         M_LAUNCH: begin
            idx = (m_pl != 0) ? m_tr : m_tl;
            m_dx = (m_pl != 0) ? -DX[idx] : DX[idx];
            m_dy = DY[idx];
            m_x = (m_pl != 0) ? 510 : 90;
            m_y = (m_pl != 0) ? 420 : 52;
            m_exist = 1;
            m_dir = (m_dx < 0) ? 1 : ((m_dx > 0) ? 0 : m_pl);
            m_fl = 0;
            m_st = M_FLIGHT;
         end
         M_FLIGHT: begin
            m_fl++;
            if (ht != 0) begin
               if (m_pl == 0) m_sl = (m_sl < 15) ? m_sl + 1 : 15;
               else           m_sr = (m_sr < 15) ? m_sr + 1 : 15;
               m_exist = 0; m_cd = 0; m_st = M_COOL;
            end else if ((m_dx > 0 && m_x + 40 + m_dx >= 640) ||
                         (m_dx < 0 && m_x < -m_dx) || m_fl == 1023) begin
               m_exist = 0; m_cd = 0; m_st = M_COOL;
            end else if (hd != 0 && m_lock == 0) begin
               m_dx = -m_dx; m_dir = 1 - m_dir; m_lock = 1;
            end else if (m_y + m_dy < 0 || m_y + 10 + m_dy > 480) begin
               m_dy = -m_dy;
            end else begin
               m_x = (m_x + m_dx) & 1023;
               m_y = (m_y + m_dy) & 1023;
            end
         end
         M_COOL: begin
            m_cd++;
            if (m_cd == 30) begin
               if (m_sl == 5 || m_sr == 5) begin m_over = 1; m_st = M_OVER; end
               else begin m_pl = 1 - m_pl; m_st = M_IDLE; end
            end
         end
         default: ;
      endcase
      if (hd == 0) m_lock = 0;
   endtask

   function automatic logic [63:0] m_pack();
      return {24'd0, 4'(m_tl), 4'(m_tr), 10'(m_x), 10'(m_y), 1'(m_exist),
              1'(m_dir), 1'(m_pl), 4'(m_sl), 4'(m_sr), 1'(m_over)};
   endfunction

   function automatic logic [63:0] dut_pack();
      return {24'd0, turret_l, turret_r, b_pos_x, b_pos_y, b_exist, b_dir,
              active_player, score_l, score_r, game_over};
   endfunction

   // One frame: drive inputs, queue the model's expectation, take the edge,
   // then compare the DUT against the oldest queued expectation.
   task automatic frame(input logic [7:0] kc, input logic hd, input logic ht, input logic rs);
      keycode = kc; hit_deflector = hd; hit_target = ht; Reset = rs;
      model_step(int'(kc), int'(hd), int'(ht), int'(rs));
      exp_q.push_back(m_pack());
      @(posedge frame_clk);
      #1;
      chk("frame", dut_pack(), exp_q.pop_front());
   endtask

   task automatic key(input logic [7:0] kc);
      frame(kc, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic press(input logic [7:0] kc);
      key(kc);
      key(8'h00);
   endtask

   task automatic fly_out(input int cap);
      for (int i = 0; i < cap; i++) begin
         if (m_exist == 0) break;
         key(8'h00);
      end
   endtask

   task automatic cooldown();
      for (int i = 0; i < 30; i++) key(8'h00);
   endtask

   localparam logic [63:0] RST_VEC = {24'd0, 4'd4, 4'd4, 10'd90, 10'd52, 1'b0,
                                      1'b0, 1'b0, 4'd0, 4'd0, 1'b0};

   initial begin
      int last_x, n_exist;

      // reset
      frame(8'h00, 1'b0, 1'b0, 1'b1);
      frame(8'h00, 1'b0, 1'b0, 1'b1);
      chk("rst_state", dut_pack(), RST_VEC);

      // aim: held key acts once, then saturates at 0
      for (int i = 0; i < 5; i++) key(8'h1A);
      chk("aim_held", 64'(turret_l), 64'd3);
      key(8'h00);
      for (int i = 0; i < 4; i++) press(8'h1A);
      chk("aim_sat0", 64'(turret_l), 64'd0);
      chk("aim_r_idle", 64'(turret_r), 64'd4);
      for (int i = 0; i < 4; i++) press(8'h16);
      chk("aim_back4", 64'(turret_l), 64'd4);

      // left shot at index 4: flat flight to a right-edge miss
      key(8'h2C);
      chk("fire_pending", 64'(b_exist), 64'd0);
      key(8'h00);
      chk("launch_pos", 64'({b_exist, b_pos_x, b_pos_y}), 64'({1'b1, 10'd90, 10'd52}));
      key(8'h00);
      chk("step_x", 64'(b_pos_x), 64'd92);
      last_x = 0;
      for (int i = 0; i < 400; i++) begin
         if (m_exist == 0) break;
         last_x = int'(b_pos_x);
         key(8'h00);
      end
      chk("miss_x", 64'(last_x), 64'd598);
      chk("miss_gone", 64'(b_exist), 64'd0);
      for (int i = 0; i < 29; i++) key(8'h00);
      chk("cd_early", 64'(active_player), 64'd0);
      key(8'h00);
      chk("cd_turn", 64'(active_player), 64'd1);

      // right player: left-side keys ignored, then aim and fire
      press(8'h1A);
      press(8'h2C);
      chk("r_ignore", 64'({turret_l, turret_r, b_exist}), 64'({4'd4, 4'd4, 1'b0}));
      press(8'h52);
      chk("r_aim", 64'(turret_r), 64'd3);
      key(8'h28);
      key(8'h00);
      chk("r_launch", 64'({b_pos_x, b_pos_y, b_dir, b_exist}), 64'({10'd510, 10'd420, 1'b1, 1'b1}));
      key(8'h00);
      chk("r_step", 64'({b_pos_x, b_pos_y}), 64'({10'd508, 10'd419}));
      fly_out(400);
      cooldown();

      // left vertical shot: top wall bounce, deflector lock, flight timeout
      for (int i = 0; i < 4; i++) press(8'h1A);
      key(8'h2C);
      key(8'h00);
      n_exist = int'(b_exist);
      for (int i = 0; i < 40; i++) begin
         if (m_y == 0) break;
         key(8'h00);
         n_exist += int'(b_exist);
      end
      chk("top_reach", 64'({b_pos_x, b_pos_y}), 64'({10'd90, 10'd0}));
      key(8'h00); n_exist += int'(b_exist);
      key(8'h00); n_exist += int'(b_exist);
      chk("bounce", 64'({b_pos_x, b_pos_y}), 64'({10'd90, 10'd2}));
      for (int i = 0; i < 3; i++) begin
         frame(8'h00, 1'b1, 1'b0, 1'b0);
         n_exist += int'(b_exist);
      end
      chk("defl_once", 64'({b_dir, b_pos_y}), 64'({1'b1, 10'd6}));
      for (int i = 0; i < 1100; i++) begin
         if (m_exist == 0) break;
         key(8'h00);
         n_exist += int'(b_exist);
      end
      chk("timeout_len", 64'(n_exist), 64'd1023);
      cooldown();

      // scoring: right misses, left hits with deflector asserted together
      for (int r = 1; r <= 5; r++) begin
         key(8'h28);
         key(8'h00);
         fly_out(400);
         cooldown();
         key(8'h2C);
         key(8'h00);
         key(8'h00);
         frame(8'h00, 1'b1, 1'b1, 1'b0);
         chk("hit_score", 64'({score_l, b_exist, b_dir}), 64'({4'(r), 1'b0, 1'b0}));
         cooldown();
      end
      chk("game_over", 64'({game_over, score_l, score_r}), 64'({1'b1, 4'd5, 4'd0}));
      press(8'h16);
      press(8'h2C);
      press(8'h28);
      frame(8'h1A, 1'b1, 1'b1, 1'b0);
      key(8'h00);
      chk("over_hold", 64'({game_over, turret_l, b_exist, score_l}), 64'({1'b1, 4'd0, 1'b0, 4'd5}));

      // reset in the middle of a flight
      frame(8'h00, 1'b0, 1'b0, 1'b1);
      key(8'h2C);
      for (int i = 0; i < 6; i++) key(8'h00);
      chk("mid_flying", 64'(b_exist), 64'd1);
      frame(8'h00, 1'b0, 1'b0, 1'b1);
      chk("rst_mid", dut_pack(), RST_VEC);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
